// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RISC-V funct3 codes, FSM state
// encoding and the request-qualification helpers used at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] LER      = 2'd1;
    localparam logic [1:0] ESCREVER = 2'd2;
    localparam logic [1:0] RESPOSTA = 2'd3;

    typedef enum logic [1:0] {
        EST_OCIOSO   = OCIOSO,
        EST_LER      = LER,
        EST_ESCREVER = ESCREVER,
        EST_RESPOSTA = RESPOSTA
    } estado_t;

    function automatic logic funct3_ilegal(input logic we, input logic [2:0] f3);
        if (we)
            return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    function automatic logic desalinhado(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return (lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    // Without the alignment check, low address bits are snapped to the access size.
    function automatic logic [1:0] forca_alinhamento(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return {lo[1], 1'b0};
            F3_W:        return 2'b00;
            default:     return lo;
        endcase
    endfunction

endpackage

// File: rtl/unidade_load_store_if.sv
// Request/response handshake plus the data-memory port of the load/store unit.
interface unidade_load_store_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_erro;
    logic [31:0] mem_rs;
    logic [31:0] mem_wd;
    logic        mem_wr;
    logic [31:0] mem_rd;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_erro
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_erro, mem_rs, mem_wd, mem_wr
    );

    modport memoria (
        input  mem_rs, mem_wd, mem_wr,
        output mem_rd
    );

endinterface

// File: rtl/alinhador_dados.sv
// Combinational lane logic: load byte/halfword select with sign/zero extension,
// and store merge of new byte/halfword into the old memory word.
module alinhador_dados
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] palavra,
    input  logic [31:0] dado,
    output logic [31:0] carga,
    output logic [31:0] mesclada
);

    logic [7:0]  byte_sel;
    logic [15:0] meia_sel;

    always_comb begin
        byte_sel = palavra[{addr_lo, 3'b000} +: 8];
        meia_sel = addr_lo[1] ? palavra[31:16] : palavra[15:0];

        carga = 32'h0;
        case (funct3)
            F3_B:    carga = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   carga = {24'h0, byte_sel};
            F3_H:    carga = {{16{meia_sel[15]}}, meia_sel};
            F3_HU:   carga = {16'h0, meia_sel};
            F3_W:    carga = palavra;
            default: carga = 32'h0;
        endcase

        // Untouched lanes keep the old word so sub-word stores preserve neighbours.
        mesclada = palavra;
        case (funct3)
            F3_B: mesclada[{addr_lo, 3'b000} +: 8] = dado[7:0];
            F3_H: begin
                if (addr_lo[1])
                    mesclada[31:16] = dado[15:0];
                else
                    mesclada[15:0] = dado[15:0];
            end
            F3_W:    mesclada = dado;
            default: mesclada = palavra;
        endcase
    end

endmodule

// File: rtl/unidade_load_store.sv
// Load/store unit driving the data memory port; sub-word stores use read-modify-write.
// Optional feature macro: LSU_CHECA_ALINHAMENTO_EN (misaligned H/W become errors).
module unidade_load_store
    import lsu_pkg::*;
#(
    parameter int PROFUNDIDADE = 1024
) (
    input logic                 clk,
    input logic                 rst_n,
    unidade_load_store_if.slave bus
);

    estado_t     estado;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic [31:0] wdata_q;
    logic        erro_req;
    logic [1:0]  lo_req;
    logic [31:0] carga;
    logic [31:0] mesclada;

    assign bus.req_ready = (estado == EST_OCIOSO);

    always_comb begin
        erro_req = funct3_ilegal(bus.req_we, bus.req_funct3);
`ifdef LSU_CHECA_ALINHAMENTO_EN
        lo_req = bus.req_addr[1:0];
        if (desalinhado(bus.req_funct3, bus.req_addr[1:0]))
            erro_req = 1'b1;
`else
        lo_req = forca_alinhamento(bus.req_funct3, bus.req_addr[1:0]);
`endif
        if ({2'b00, bus.req_addr[31:2]} >= 32'(PROFUNDIDADE))
            erro_req = 1'b1;
    end

    alinhador_dados u_alinhador (
        .funct3   (f3_q),
        .addr_lo  (lo_q),
        .palavra  (bus.mem_rd),
        .dado     (wdata_q),
        .carga    (carga),
        .mesclada (mesclada)
    );

    // Response and write strobes default low so each is a single-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado         <= EST_OCIOSO;
            we_q           <= 1'b0;
            f3_q           <= 3'b000;
            lo_q           <= 2'b00;
            wdata_q        <= 32'h0;
            bus.resp_valid <= 1'b0;
            bus.resp_erro  <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.mem_rs     <= 32'h0;
            bus.mem_wd     <= 32'h0;
            bus.mem_wr     <= 1'b0;
        end else begin
            bus.resp_valid <= 1'b0;
            bus.resp_erro  <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.mem_wd     <= 32'h0;
            bus.mem_wr     <= 1'b0;
            case (estado)
                EST_OCIOSO: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        f3_q    <= bus.req_funct3;
                        lo_q    <= lo_req;
                        wdata_q <= bus.req_wdata;
                        if (erro_req) begin
                            estado         <= EST_RESPOSTA;
                            bus.resp_valid <= 1'b1;
                            bus.resp_erro  <= 1'b1;
                        end else begin
                            bus.mem_rs <= {2'b00, bus.req_addr[31:2]};
                            if (bus.req_we && bus.req_funct3 == F3_W) begin
                                estado     <= EST_ESCREVER;
                                bus.mem_wd <= bus.req_wdata;
                                bus.mem_wr <= 1'b1;
                            end else begin
                                estado <= EST_LER;
                            end
                        end
                    end
                end
                EST_LER: begin
                    if (we_q) begin
                        estado     <= EST_ESCREVER;
                        bus.mem_wd <= mesclada;
                        bus.mem_wr <= 1'b1;
                    end else begin
                        estado         <= EST_RESPOSTA;
                        bus.resp_valid <= 1'b1;
                        bus.resp_rdata <= carga;
                    end
                end
                EST_ESCREVER: begin
                    estado         <= EST_RESPOSTA;
                    bus.resp_valid <= 1'b1;
                end
                EST_RESPOSTA: begin
                    estado <= EST_OCIOSO;
                end
                default: begin
                    estado <= EST_OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_load_store.sv
// Scoreboard bench for unidade_load_store with a behavioural 1024-word memory.
// Expectations for misaligned requests follow LSU_CHECA_ALINHAMENTO_EN.
module tb_unidade_load_store;
    import lsu_pkg::*;

    typedef struct {
        logic        erro;
        logic [31:0] rdata;
        int          lat;
        int          c0;
        string       nome;
    } esperado_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    esperado_t   sb[$];
    esperado_t   mon_e;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          wr_count = 0;
    int          wd_viol = 0;
    int          w0;
    logic [31:0] last_wr_idx = 32'h0;
    bit   [31:0] mem [0:1023];
    bit          mem_init = 1'b0;

    always #5 clk = ~clk;

    unidade_load_store_if bus ();

    unidade_load_store #(.PROFUNDIDADE(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: preload on first edge, then honour the unit's write strobe.
    always @(posedge clk) begin
        if (!mem_init) begin
            mem[1]    <= 32'hCAFEBABE;
            mem[5]    <= 32'h8899AABB;
            mem[100]  <= 32'h11223344;
            mem[1023] <= 32'h12345678;
            mem_init  <= 1'b1;
        end else if (bus.mem_wr && bus.mem_rs < 32'd1024) begin
            mem[bus.mem_rs[9:0]] <= bus.mem_wd;
            last_wr_idx          <= bus.mem_rs;
        end
    end

    assign bus.mem_rd = (bus.mem_rs < 32'd1024) ? mem[bus.mem_rs[9:0]] : 32'h0;

    task automatic checkOutput(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        checks++;
        if (atual !== esperado) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", nome, atual, esperado);
        end
    endtask

    // Monitor: pops the scoreboard on every response and tracks write activity.
    always @(negedge clk) begin
        if (bus.mem_wr)
            wr_count++;
        else if (bus.mem_wd !== 32'h0)
            wd_viol++;
        if (bus.resp_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                checkOutput({mon_e.nome, "_erro"}, {31'h0, bus.resp_erro}, {31'h0, mon_e.erro});
                checkOutput({mon_e.nome, "_rdata"}, bus.resp_rdata, mon_e.rdata);
                checkOutput({mon_e.nome, "_lat"}, 32'(cyc - mon_e.c0), 32'(mon_e.lat));
            end
        end
    end

    task automatic applyStimulus(input string nome, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic exp_erro, input logic [31:0] exp_rdata,
                                 input int exp_lat, input bit esperar_resp);
        int espera = 0;
        @(negedge clk);
        while (!bus.req_ready && espera < 20) begin
            @(negedge clk);
            espera++;
        end
        if (!bus.req_ready) begin
            checkOutput({nome, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        if (esperar_resp)
            sb.push_back('{erro: exp_erro, rdata: exp_rdata, lat: exp_lat, c0: cyc, nome: nome});
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic waitIdle(input string nome);
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !bus.req_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || !bus.req_ready)
            checkOutput({nome, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_req_ready", {31'h0, bus.req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'h0, bus.resp_valid}, 32'd0);
        checkOutput("rst_resp_rdata", bus.resp_rdata, 32'h0);
        checkOutput("rst_mem_rs", bus.mem_rs, 32'h0);
        checkOutput("rst_mem_wd", bus.mem_wd, 32'h0);
        checkOutput("rst_mem_wr", {31'h0, bus.mem_wr}, 32'd0);
        rst_n = 1'b1;

        // Loads from word 5 = 8899AABB
        applyStimulus("lb_22",  1'b0, F3_B,  32'd22, 32'h0, 1'b0, 32'hFFFFFF99, 2, 1'b1);
        applyStimulus("lhu_22", 1'b0, F3_HU, 32'd22, 32'h0, 1'b0, 32'h00008899, 2, 1'b1);
        applyStimulus("lh_20",  1'b0, F3_H,  32'd20, 32'h0, 1'b0, 32'hFFFFAABB, 2, 1'b1);
        applyStimulus("lbu_23", 1'b0, F3_BU, 32'd23, 32'h0, 1'b0, 32'h00000088, 2, 1'b1);
        waitIdle("loads");

        w0 = wr_count;
        applyStimulus("sw_2000", 1'b1, F3_W, 32'd2000, 32'd2000, 1'b0, 32'h0, 2, 1'b1);
        waitIdle("sw_2000");
        checkOutput("sw_2000_wr_pulses", 32'(wr_count - w0), 32'd1);
        checkOutput("sw_2000_index", last_wr_idx, 32'd500);
        checkOutput("sw_2000_mem", mem[500], 32'd2000);
        applyStimulus("lw_2000", 1'b0, F3_W, 32'd2000, 32'h0, 1'b0, 32'd2000, 2, 1'b1);

        w0 = wr_count;
        applyStimulus("sb_401", 1'b1, F3_B, 32'd401, 32'h000000FF, 1'b0, 32'h0, 3, 1'b1);
        waitIdle("sb_401");
        checkOutput("sb_401_wr_pulses", 32'(wr_count - w0), 32'd1);
        checkOutput("sb_401_mem", mem[100], 32'h1122FF44);
        applyStimulus("sh_402", 1'b1, F3_H, 32'd402, 32'h1234BEEF, 1'b0, 32'h0, 3, 1'b1);
        waitIdle("sh_402");
        checkOutput("sh_402_mem", mem[100], 32'hBEEFFF44);

        w0 = wr_count;
`ifdef LSU_CHECA_ALINHAMENTO_EN
        applyStimulus("lw_6", 1'b0, F3_W, 32'd6,  32'h0, 1'b1, 32'h0, 1, 1'b1);
        applyStimulus("lh_21", 1'b0, F3_H, 32'd21, 32'h0, 1'b1, 32'h0, 1, 1'b1);
`else
        applyStimulus("lw_6", 1'b0, F3_W, 32'd6,  32'h0, 1'b0, 32'hCAFEBABE, 2, 1'b1);
        applyStimulus("lh_21", 1'b0, F3_H, 32'd21, 32'h0, 1'b0, 32'hFFFFAABB, 2, 1'b1);
`endif
        applyStimulus("ld_f3_011", 1'b0, 3'b011, 32'd0,    32'h0, 1'b1, 32'h0, 1, 1'b1);
        applyStimulus("st_f3_100", 1'b1, 3'b100, 32'd0,    32'h5, 1'b1, 32'h0, 1, 1'b1);
        applyStimulus("sw_4096",   1'b1, F3_W,   32'd4096, 32'h9, 1'b1, 32'h0, 1, 1'b1);
        applyStimulus("lw_4092",   1'b0, F3_W,   32'd4092, 32'h0, 1'b0, 32'h12345678, 2, 1'b1);
        waitIdle("errors");
        checkOutput("errors_wr_pulses", 32'(wr_count - w0), 32'd0);

        // Reset asserted while the SB sits in its read phase.
        w0 = wr_count;
        applyStimulus("sb_abort", 1'b1, F3_B, 32'd400, 32'h00000077, 1'b0, 32'h0, 0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("abort_mem_wr_in_reset", {31'h0, bus.mem_wr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_req_ready", {31'h0, bus.req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        checkOutput("abort_wr_pulses", 32'(wr_count - w0), 32'd0);
        checkOutput("abort_mem", mem[100], 32'hBEEFFF44);

        applyStimulus("lw_400", 1'b0, F3_W, 32'd400, 32'h0, 1'b0, 32'hBEEFFF44, 2, 1'b1);
        waitIdle("fim");
        checkOutput("mem_wd_outside_write", 32'(wd_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
